// File: rtl/move_controller_pkg.sv
// Shared constants for the move controller: move indices, FSM encoding and LFSR helpers.
package move_controller_pkg;

    localparam int unsigned NUM_MOVES = 4;

    localparam int unsigned MV_ROTATE = 0;
    localparam int unsigned MV_LEFT   = 1;
    localparam int unsigned MV_RIGHT  = 2;
    localparam int unsigned MV_DOWN   = 3;

    localparam logic [15:0] LFSR_MASK         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] COOL = 1'b1;

    typedef logic [NUM_MOVES-1:0] moveVec_t;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/move_controller_button_conditioner.sv
// Synchronizes, debounces and edge-detects one raw button; rise pulses once per accepted press.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic rawButton,
    output logic rise
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             syncA;
    logic             syncB;
    logic             stable;
    logic [CNT_W-1:0] count;
    logic             flip;

    assign flip = (syncB != stable) && (count == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            syncA  <= 1'b0;
            syncB  <= 1'b0;
            stable <= 1'b0;
            count  <= '0;
            rise   <= 1'b0;
        end else begin
            syncA <= rawButton;
            syncB <= syncA;
            rise  <= flip && !stable;
            if (syncB == stable) begin
                count <= '0;
            end else if (flip) begin
                count  <= '0;
                stable <= ~stable;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/move_controller.sv
// Turns debounced buttons and a gravity timer into spaced, one-hot move requests;
// also supplies a free-running pseudo-random piece selector.
module move_controller
    import move_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned GRAVITY_CYCLES  = 50000000,
    parameter int unsigned GAP_CYCLES      = 2,
    parameter logic [15:0] LFSR_SEED       = LFSR_DEFAULT_SEED
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic       btnDown,
    input  logic       btnRotate,
    input  logic [1:0] level,
    input  logic       pause,
    output logic       leftTrue,
    output logic       rightTrue,
    output logic       downTrue,
    output logic       rotateTrue,
    output logic [2:0] blockType
);

    localparam int unsigned GRAV_W = $clog2(GRAVITY_CYCLES + 1);
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    moveVec_t          rawButtons;
    moveVec_t          buttonRise;
    moveVec_t          pending;
    moveVec_t          requests;
    moveVec_t          grant;
    moveVec_t          moveOut;
    logic [GRAV_W-1:0] gravityCount;
    logic [31:0]       gravityPeriod;
    logic              gravityTick;
    logic [0:0]        state;
    logic [0:0]        stateNext;
    logic [GAP_W-1:0]  coolCount;
    logic [GAP_W-1:0]  coolNext;
    logic              armed;
    logic [15:0]       lfsr;

    assign rawButtons[MV_ROTATE] = btnRotate;
    assign rawButtons[MV_LEFT]   = btnLeft;
    assign rawButtons[MV_RIGHT]  = btnRight;
    assign rawButtons[MV_DOWN]   = btnDown;

    for (genvar i = 0; i < NUM_MOVES; i++) begin : gButton
        button_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) uCond (
            .clock    (clock),
            .reset    (reset),
            .rawButton(rawButtons[i]),
            .rise     (buttonRise[i])
        );
    end

    // Fresh ticks and edges merge with sticky flags so a same-cycle tick and press issue once.
    assign gravityPeriod = GRAVITY_CYCLES >> level;
    assign gravityTick   = !pause && ((32'(gravityCount) + 32'd1) >= gravityPeriod);

    always_comb begin
        requests          = pending | buttonRise;
        requests[MV_DOWN] = requests[MV_DOWN] | gravityTick;
    end

    // Arbiter FSM: issue one request from IDLE, then hold off for the cooldown.
    always_comb begin
        stateNext = state;
        coolNext  = coolCount;
        grant     = '0;
        case (state)
            IDLE: begin
                if (armed && !pause && (requests != '0)) begin
                    if (requests[MV_ROTATE])     grant[MV_ROTATE] = 1'b1;
                    else if (requests[MV_LEFT])  grant[MV_LEFT]   = 1'b1;
                    else if (requests[MV_RIGHT]) grant[MV_RIGHT]  = 1'b1;
                    else                         grant[MV_DOWN]   = 1'b1;
                    coolNext  = GAP_W'(GAP_CYCLES);
                    stateNext = COOL;
                end
            end
            COOL: begin
                if (coolCount <= GAP_W'(1)) begin
                    coolNext  = '0;
                    stateNext = IDLE;
                end else begin
                    coolNext = coolCount - GAP_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            coolCount <= '0;
            moveOut   <= '0;
            pending   <= '0;
            armed     <= 1'b0;
        end else begin
            state     <= stateNext;
            coolCount <= coolNext;
            moveOut   <= grant;
            pending   <= requests & ~grant;
            armed     <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gravityCount <= '0;
        end else if (!pause) begin
            if (gravityTick || grant[MV_DOWN]) gravityCount <= '0;
            else                               gravityCount <= gravityCount + GRAV_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= lfsrNext(lfsr);
    end

    assign rotateTrue = moveOut[MV_ROTATE];
    assign leftTrue   = moveOut[MV_LEFT];
    assign rightTrue  = moveOut[MV_RIGHT];
    assign downTrue   = moveOut[MV_DOWN];
    assign blockType  = lfsr[2:0];

endmodule

// File: tb/tb_move_controller.sv
// Scoreboard bench for move_controller with small debounce/gravity parameters.
module tb_move_controller;
    import move_controller_pkg::*;

    localparam int unsigned DEB  = 4;
    localparam int unsigned GRAV = 20;
    localparam int unsigned GAP  = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       btnLeft = 1'b0;
    logic       btnRight = 1'b0;
    logic       btnDown = 1'b0;
    logic       btnRotate = 1'b0;
    logic [1:0] level = 2'd0;
    logic       pause = 1'b0;
    logic       leftTrue;
    logic       rightTrue;
    logic       downTrue;
    logic       rotateTrue;
    logic [2:0] blockType;

    move_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .GRAVITY_CYCLES (GRAV),
        .GAP_CYCLES     (GAP),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btnLeft   (btnLeft),
        .btnRight  (btnRight),
        .btnDown   (btnDown),
        .btnRotate (btnRotate),
        .level     (level),
        .pause     (pause),
        .leftTrue  (leftTrue),
        .rightTrue (rightTrue),
        .downTrue  (downTrue),
        .rotateTrue(rotateTrue),
        .blockType (blockType)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cyc;
        int val;
    } expItem_t;

    expItem_t reqQ[$];
    expItem_t btQ[$];
    int       cyc = 0;
    int       nChecks = 0;
    int       nPass = 0;
    logic [3:0] outs;

    task automatic check(input string name, input bit ok, input int act, input int exp);
        nChecks++;
        if (ok) nPass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [15:0] galois(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic pushReq(input int c, input int unsigned mv);
        reqQ.push_back('{c, 1 << mv});
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic waitCyc(input int k);
        while (cyc < k) @(negedge clock);
    endtask

    task automatic endScenario(input string name, input int endCyc);
        waitCyc(endCyc);
        check({name, "_drained"}, reqQ.size() == 0, reqQ.size(), 0);
        reqQ.delete();
    endtask

    // Cycle number = count of active edges since reset was released.
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Monitor: pops the scoreboard whenever any request output is high.
    always @(posedge clock) begin
        expItem_t e;
        #1;
        outs = {downTrue, rightTrue, leftTrue, rotateTrue};
        if (reset) check("reset_outs", outs == 4'b0000, int'(outs), 0);
        if (outs != 4'b0000) begin
            check("one_hot", $countones(outs) == 1, int'(outs), 1);
            check("req_expected", reqQ.size() > 0, int'(outs), 0);
            if (reqQ.size() > 0) begin
                e = reqQ.pop_front();
                check("req_code", int'(outs) == e.val, int'(outs), e.val);
                check("req_cycle", cyc == e.cyc, cyc, e.cyc);
            end
        end
        if (btQ.size() > 0 && btQ[0].cyc == cyc) begin
            e = btQ.pop_front();
            check("block_type", int'(blockType) == e.val, int'(blockType), e.val);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench exceeded its time limit (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [15:0] st;
        int          hand[7];
        logic [3:0]  now;

        // S1: glitchy left press, then long hold
        doReset();
        btnLeft = 1'b1;
        pushReq(12, MV_LEFT);
        for (int c = 20; c <= 120; c += 20) pushReq(c, MV_DOWN);
        waitCyc(2);   btnLeft = 1'b0;
        waitCyc(3);   btnLeft = 1'b1;
        waitCyc(4);   btnLeft = 1'b0;
        waitCyc(5);   btnLeft = 1'b1;
        waitCyc(112); btnLeft = 1'b0;
        endScenario("s1", 125);

        // S2: rotate and left accepted together
        doReset();
        btnRotate = 1'b1;
        btnLeft   = 1'b1;
        pushReq(7, MV_ROTATE);
        pushReq(10, MV_LEFT);
        pushReq(20, MV_DOWN);
        pushReq(40, MV_DOWN);
        waitCyc(15);
        btnRotate = 1'b0;
        btnLeft   = 1'b0;
        endScenario("s2", 45);

        // S3: gravity at level 0 and 2, button down restarts gravity, mid-count level raise
        doReset();
        pushReq(20, MV_DOWN);  pushReq(40, MV_DOWN);  pushReq(60, MV_DOWN);
        pushReq(65, MV_DOWN);  pushReq(70, MV_DOWN);  pushReq(75, MV_DOWN);
        pushReq(80, MV_DOWN);  pushReq(100, MV_DOWN); pushReq(117, MV_DOWN);
        pushReq(137, MV_DOWN); pushReq(148, MV_DOWN); pushReq(168, MV_DOWN);
        waitCyc(60);  level = 2'd2;
        waitCyc(80);  level = 2'd0;
        waitCyc(110); btnDown = 1'b1;
        waitCyc(120); btnDown = 1'b0;
        waitCyc(147); level = 2'd2;
        waitCyc(148); level = 2'd0;
        endScenario("s3", 172);

        // S4: down edge coincides with a gravity tick
        doReset();
        pushReq(20, MV_DOWN);
        pushReq(40, MV_DOWN);
        waitCyc(13); btnDown = 1'b1;
        waitCyc(25); btnDown = 1'b0;
        endScenario("s4", 45);

        // S5: right pressed during pause
        pause = 1'b1;
        doReset();
        btnRight = 1'b1;
        pushReq(51, MV_RIGHT);
        pushReq(70, MV_DOWN);
        waitCyc(50); pause = 1'b0;
        waitCyc(60); btnRight = 1'b0;
        endScenario("s5", 75);

        // S6a: LFSR sequence from reset
        hand = '{1, 0, 0, 4, 6, 7, 3};
        for (int k = 0; k < 7; k++) btQ.push_back('{k, hand[k]});
        st = 16'hB313;
        for (int k = 7; k <= 16; k++) begin
            st = galois(st);
            btQ.push_back('{k, int'(st[2:0])});
        end
        doReset();
        endScenario("s6a", 17);
        check("bt_drained", btQ.size() == 0, btQ.size(), 0);

        // S6b: reset lands on a rotate pulse while left is still pending
        doReset();
        btnRotate = 1'b1;
        btnLeft   = 1'b1;
        pushReq(7, MV_ROTATE);
        waitCyc(7);
        reset     = 1'b1;
        btnRotate = 1'b0;
        btnLeft   = 1'b0;
        #1;
        now = {downTrue, rightTrue, leftTrue, rotateTrue};
        check("reset_drop", now == 4'b0000, int'(now), 0);
        check("reset_seed", blockType == 3'd1, int'(blockType), 1);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        pushReq(20, MV_DOWN);
        endScenario("s6b", 25);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
